ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: data_width, 12, RAM word width in bits.
REQ-002 SHALL have parameter: addr_width, 6, RAM address width in bits (depth 2**addr_width).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: req0, req1  input  1 each  access request from requester 0/1.
REQ-006 SHALL have ports: we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have ports: addr0, addr1  input  addr_width each  access address.
REQ-008 SHALL have ports: wdata0, wdata1  input  data_width each  write data.
REQ-009 SHALL have ports: gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports: rvalid0, rvalid1  output  1 each  read data valid for requester.
REQ-011 SHALL have ports: rdata0, rdata1  output  data_width each  read data.
REQ-012 SHALL have ports: ram_we  output  1; ram_addr  output  addr_width; ram_din  output  data_width; command to sp_ram we/addr/data_in.
REQ-013 SHALL have port: ram_dout  input  data_width  from sp_ram data_out; sp_ram is a synchronous-read RAM, output valid the cycle after the address is sampled.

Function
REQ-014 Requester holds req/we/addr/wdata stable until it sees gnt high; the transfer completes in the cycle gnt is high.
REQ-015 gnt0/gnt1 SHALL be combinational from req and the priority pointer; at most one high per cycle; gnt never high without matching req.
REQ-016 Arbitration: one requester -> grant it; both -> grant the one not granted most recently (round-robin); neither -> no grant.
REQ-017 Priority pointer SHALL update only on a grant, to mark the granted requester as last served.
REQ-018 Granted command in cycle N SHALL appear registered on ram_we/ram_addr/ram_din in cycle N+1; no grant -> ram_we = 0, ram_addr/ram_din hold.
REQ-019 Read granted in cycle N: rvalid of that requester SHALL be high for exactly cycle N+2, with rdata = ram_dout; read latency fixed at 2 cycles from gnt.
REQ-020 Write granted in cycle N: no rvalid; ram_we high in cycle N+1 only.
REQ-021 rdataK SHALL equal ram_dout when rvalidK = 1, else 0.
REQ-022 Back-to-back grants every cycle SHALL be supported (throughput 1 access/cycle); up to two reads in flight, tracked by a 2-stage owner/read pipeline.
REQ-023 Write to address A granted cycle N followed by read of A granted cycle N+1 (any requester) SHALL return the new data.
REQ-024 Continuous contention SHALL alternate grants 0,1,0,1,...; neither requester waits more than 1 cycle.

Reset
REQ-025 On rst: gnt0/gnt1 = 0, ram_we = 0, ram_addr = 0, ram_din = 0, rvalid0/rvalid1 = 0, rdata0/rdata1 = 0; pointer favours requester 0 first.
REQ-026 rst mid-operation SHALL discard in-flight reads (no rvalid after release) and force ram_we low immediately (asynchronous).
REQ-027 First rising edge after rst deassertion SHALL arbitrate normally.

Structure
REQ-028 Shared package ram_arb_pkg SHALL hold defaults DATA_WIDTH = 12, ADDR_WIDTH = 6, READ_LATENCY = 2, requester index constants REQ0 = 0, REQ1 = 1.
REQ-029 Grant logic and pointer SHALL live in sub-module rr_arb2 (2-way round-robin); ram_arbiter holds command register and read-return pipeline.
REQ-030 Bench SHALL instantiate ram_arbiter driving one sp_ram (data_width 12, addr_width 6, init_value 0).

Verification
REQ-031 Only req0, write addr 5 data 0xABC, then read addr 5 -> gnt0 each request; rvalid0 two cycles after read gnt, rdata0 = 0xABC; rvalid1 stays 0.
REQ-032 req0 and req1 both held reading addr 1 and 2 for 6 cycles after reset -> gnt order 0,1,0,1,0,1; rvalid alternates with correct data per owner.
REQ-033 req1 writes addr 63 = 0xFFF granted cycle N, req0 reads addr 63 granted N+1 -> rvalid0 at N+3, rdata0 = 0xFFF.
REQ-034 req0 fills addr 0..63 with data = addr, then req1 reads 0..63 back-to-back -> 64 rvalid1 pulses in consecutive cycles, rdata1 = addr.
REQ-035 rst asserted one cycle after a read grant -> ram_we = 0 and no rvalid pulse; after release, a read of addr 0 returns stored value.
REQ-036 No requests for 10 cycles -> gnt0 = gnt1 = 0, ram_we = 0, rvalid0 = rvalid1 = 0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// The arbiter and its round-robin sub-block both import this package.
package ram_arb_pkg;

  localparam int DATA_WIDTH   = 12;
  localparam int ADDR_WIDTH   = 6;
  localparam int READ_LATENCY = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One stage of the read-return pipeline: a read is in flight, and who asked for it
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_stage_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grants plus a last-served pointer.
// Grants are held low while reset is asserted.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_last;
  logic w_gnt0;
  logic w_gnt1;

  // On contention the requester that was not served most recently wins
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (i_req0 && (!i_req1 || (r_last == REQ1))) begin
        w_gnt0 = 1'b1;
      end else if (i_req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // Starting "last served = 1" makes requester 0 win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ1;
    end else if (w_gnt0) begin
      r_last <= REQ0;
    end else if (w_gnt1) begin
      r_last <= REQ1;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/sp_ram.sv
// Single-port synchronous-read RAM: data_out shows the word at the address
// sampled on the previous rising edge (read-before-write on a collision).
module sp_ram #(
  parameter int                   data_width = 12,
  parameter int                   addr_width = 6,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out
);

  logic [data_width-1:0] r_mem [2**addr_width] = '{default: init_value};

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= data_in;
    end
    data_out <= r_mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous-read RAM between two requesters: registers the granted
// command toward the RAM and routes read data back after a fixed latency.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_gntAny;
  logic                  w_we;
  logic [addr_width-1:0] w_addr;
  logic [data_width-1:0] w_din;

  logic                  r_ramWe;
  logic [addr_width-1:0] r_ramAddr;
  logic [data_width-1:0] r_ramDin;
  rd_stage_t             r_pipe [READ_LATENCY];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (req0),
    .i_req1 (req1),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_comb begin
    w_gntAny = w_gnt0 | w_gnt1;
    w_we     = we0;
    w_addr   = addr0;
    w_din    = wdata0;
    if (w_gnt1) begin
      w_we   = we1;
      w_addr = addr1;
      w_din  = wdata1;
    end
  end

  // Address and data hold their last value when idle; only the write strobe drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramWe   <= 1'b0;
      r_ramAddr <= '0;
      r_ramDin  <= '0;
    end else begin
      r_ramWe <= w_gntAny & w_we;
      if (w_gntAny) begin
        r_ramAddr <= w_addr;
        r_ramDin  <= w_din;
      end
    end
  end

  // Stage 0 lines up with the RAM sampling the address, the last stage with ram_dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_gntAny & ~w_we;
      r_pipe[0].owner <= w_gnt1 ? REQ1 : REQ0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign ram_we   = r_ramWe;
  assign ram_addr = r_ramAddr;
  assign ram_din  = r_ramDin;

  assign rvalid0 = r_pipe[READ_LATENCY-1].valid && (r_pipe[READ_LATENCY-1].owner == REQ0);
  assign rvalid1 = r_pipe[READ_LATENCY-1].valid && (r_pipe[READ_LATENCY-1].owner == REQ1);
  assign rdata0  = rvalid0 ? ram_dout : '0;
  assign rdata1  = rvalid1 ? ram_dout : '0;

endmodule
